// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache/main-memory arbiter.
package cache_arb_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned WORD_IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL,
        TAG
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/word_onehot.sv
// Word index to one-hot word select for the cache data-array fill port.
module word_onehot
    import cache_arb_pkg::*;
(
    input  logic [WORD_IDX_W-1:0]      idx,
    output logic [WORDS_PER_BLOCK-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares main memory between I-fill, D-fill and D write-through.
// Optional round-robin I/D fill arbitration: define CACHE_ARB_RR_EN.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifill_req,
    input  logic [ADDR_W-1:0] ifill_addr,
    input  logic              dfill_req,
    input  logic [ADDR_W-1:0] dfill_addr,
    input  logic              dwr_req,
    input  logic [ADDR_W-1:0] dwr_addr,
    input  logic [DATA_W-1:0] dwr_data,
    output logic              dwr_ack,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvld,
    output logic [DATA_W-1:0] fill_data,
    output logic [7:0]        fill_word_sel,
    output logic              fill_we_i,
    output logic              fill_we_d,
    output logic              tag_we_i,
    output logic              tag_we_d,
    output logic              ifill_done,
    output logic              dfill_done,
    output logic              ibusy,
    output logic              dbusy
);

    if (MEM_LATENCY < 1) begin : g_latency_check
        $error("MEM_LATENCY must be at least 1");
    end

    state_e                   state_q, state_d;
    owner_e                   own_q, own_d;
    logic [WORD_IDX_W-1:0]    ic_q, ic_d;
    logic [3:0]               rc_q, rc_d;
    logic                     mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]        fill_data_q, fill_data_d;
    logic [7:0]               fill_word_sel_q, fill_word_sel_d;
    logic                     fill_we_i_q, fill_we_i_d, fill_we_d_q, fill_we_d_d;
    logic                     done_i_q, done_i_d, done_d_q, done_d_d;
    logic                     dwr_ack_q, dwr_ack_d;
    logic                     ibusy_q, ibusy_d, dbusy_q, dbusy_d;
    logic                     pick_dfill;
    logic [ADDR_W-1:0]        fill_addr;
    logic [WORDS_PER_BLOCK-1:0] word_sel;
    logic                     unused_addr_lsbs;
`ifdef CACHE_ARB_RR_EN
    owner_e                   rr_q, rr_d;
`endif

    assign unused_addr_lsbs = ^{ifill_addr[3:0], dfill_addr[3:0]};

    word_onehot u_word_onehot (
        .idx    (rc_q[WORD_IDX_W-1:0]),
        .onehot (word_sel)
    );

    always_comb begin
        state_d         = state_q;
        own_d           = own_q;
        ic_d            = ic_q;
        rc_d            = rc_q;
        mem_en_d        = 1'b0;
        mem_wr_d        = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        fill_data_d     = fill_data_q;
        fill_word_sel_d = fill_word_sel_q;
        fill_we_i_d     = 1'b0;
        fill_we_d_d     = 1'b0;
        done_i_d        = 1'b0;
        done_d_d        = 1'b0;
        dwr_ack_d       = 1'b0;
        pick_dfill      = 1'b0;
        fill_addr       = '0;
`ifdef CACHE_ARB_RR_EN
        rr_d            = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef CACHE_ARB_RR_EN
                // rr_q names the fill class that wins the next I/D tie
                pick_dfill = dfill_req && (!ifill_req || rr_q == OWN_D);
`else
                pick_dfill = dfill_req;
`endif
                fill_addr = pick_dfill ? dfill_addr : ifill_addr;
                if (dwr_req) begin
                    state_d     = WRITE;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = dwr_addr;
                    mem_wdata_d = dwr_data;
                    dwr_ack_d   = 1'b1;
                end else if (dfill_req || ifill_req) begin
                    state_d    = FILL;
                    own_d      = pick_dfill ? OWN_D : OWN_I;
                    ic_d       = '0;
                    rc_d       = '0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = {fill_addr[ADDR_W-1:4], 4'b0000};
`ifdef CACHE_ARB_RR_EN
                    rr_d       = pick_dfill ? OWN_I : OWN_D;
`endif
                end
            end
            WRITE: state_d = IDLE;
            FILL: begin
                // mem_addr_q already carries the latched block address
                if (mem_en_q && ic_q != 3'd7) begin
                    ic_d       = ic_q + 3'd1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = {mem_addr_q[ADDR_W-1:4], ic_q + 3'd1, 1'b0};
                end
                if (mem_rvld && rc_q != 4'(WORDS_PER_BLOCK)) begin
                    rc_d            = rc_q + 4'd1;
                    fill_data_d     = mem_rdata;
                    fill_word_sel_d = word_sel;
                    fill_we_i_d     = (own_q == OWN_I);
                    fill_we_d_d     = (own_q == OWN_D);
                end
                if (rc_q == 4'(WORDS_PER_BLOCK)) begin
                    state_d  = TAG;
                    done_i_d = (own_q == OWN_I);
                    done_d_d = (own_q == OWN_D);
                end
            end
            TAG: state_d = IDLE;
        endcase
        ibusy_d = (state_d == FILL || state_d == TAG) && own_d == OWN_I;
        dbusy_d = (state_d == WRITE) ||
                  ((state_d == FILL || state_d == TAG) && own_d == OWN_D);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            own_q           <= OWN_I;
            ic_q            <= '0;
            rc_q            <= '0;
            mem_en_q        <= 1'b0;
            mem_wr_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            fill_data_q     <= '0;
            fill_word_sel_q <= '0;
            fill_we_i_q     <= 1'b0;
            fill_we_d_q     <= 1'b0;
            done_i_q        <= 1'b0;
            done_d_q        <= 1'b0;
            dwr_ack_q       <= 1'b0;
            ibusy_q         <= 1'b0;
            dbusy_q         <= 1'b0;
`ifdef CACHE_ARB_RR_EN
            rr_q            <= OWN_D;
`endif
        end else begin
            state_q         <= state_d;
            own_q           <= own_d;
            ic_q            <= ic_d;
            rc_q            <= rc_d;
            mem_en_q        <= mem_en_d;
            mem_wr_q        <= mem_wr_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            fill_data_q     <= fill_data_d;
            fill_word_sel_q <= fill_word_sel_d;
            fill_we_i_q     <= fill_we_i_d;
            fill_we_d_q     <= fill_we_d_d;
            done_i_q        <= done_i_d;
            done_d_q        <= done_d_d;
            dwr_ack_q       <= dwr_ack_d;
            ibusy_q         <= ibusy_d;
            dbusy_q         <= dbusy_d;
`ifdef CACHE_ARB_RR_EN
            rr_q            <= rr_d;
`endif
        end
    end

    assign dwr_ack       = dwr_ack_q;
    assign mem_en        = mem_en_q;
    assign mem_wr        = mem_wr_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign fill_data     = fill_data_q;
    assign fill_word_sel = fill_word_sel_q;
    assign fill_we_i     = fill_we_i_q;
    assign fill_we_d     = fill_we_d_q;
    assign tag_we_i      = done_i_q;
    assign tag_we_d      = done_d_q;
    assign ifill_done    = done_i_q;
    assign dfill_done    = done_d_q;
    assign ibusy         = ibusy_q;
    assign dbusy         = dbusy_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: transaction-level timing model plus memory model.
module tb_cache_mem_arbiter;

    localparam int L = 4;

    logic        clk, rst;
    logic        ifill_req, dfill_req, dwr_req;
    logic [15:0] ifill_addr, dfill_addr, dwr_addr, dwr_data;
    logic        dwr_ack, mem_en, mem_wr, mem_rvld;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic [7:0]  fill_word_sel;
    logic        fill_we_i, fill_we_d, tag_we_i, tag_we_d;
    logic        ifill_done, dfill_done, ibusy, dbusy;
    logic [10:0] ctl;

    int total = 0, bad = 0, timeouts = 0;
    bit gap_mode = 0, spur = 0;
    logic [15:0] memw [logic [15:0]];

    cache_mem_arbiter #(.MEM_LATENCY(L), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .ifill_req(ifill_req), .ifill_addr(ifill_addr),
        .dfill_req(dfill_req), .dfill_addr(dfill_addr),
        .dwr_req(dwr_req), .dwr_addr(dwr_addr), .dwr_data(dwr_data), .dwr_ack(dwr_ack),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvld(mem_rvld),
        .fill_data(fill_data), .fill_word_sel(fill_word_sel),
        .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
        .tag_we_i(tag_we_i), .tag_we_d(tag_we_d),
        .ifill_done(ifill_done), .dfill_done(dfill_done),
        .ibusy(ibusy), .dbusy(dbusy)
    );

    assign ctl = {mem_en, mem_wr, dwr_ack, fill_we_i, fill_we_d, tag_we_i, tag_we_d,
                  ifill_done, dfill_done, ibusy, dbusy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] memval(input logic [15:0] a);
        if (memw.exists(a)) return memw[a];
        return a ^ 16'hC3A5;
    endfunction

    // Requesters drop their level request in the cycle their ack/done shows.
    task automatic tick();
        @(negedge clk);
        if (dwr_ack) dwr_req = 1'b0;
        if (ifill_done) ifill_req = 1'b0;
        if (dfill_done) dfill_req = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((dwr_req || dfill_req || ifill_req) && n < budget) begin
            tick();
            n++;
        end
        if (dwr_req || dfill_req || ifill_req) begin
            timeouts++;
            dwr_req = 1'b0; dfill_req = 1'b0; ifill_req = 1'b0;
        end
        repeat (3) tick();
    endtask

    // Reference model and memory: cycle c is observed 2ns after its negedge.
    initial begin
        int cyc = 0, m_free = 0, m_kind = 0, m_start = 0, m_ret = 0, m_done = -1;
        logic [15:0] m_addr = '0, m_wdata = '0, s_data = '0;
        logic [7:0] s_sel = '0;
        bit s_exp = 0, rr_pref_d = 1, pick, is_d, act;
        bit e_en, e_wr, e_ack, e_wei, e_wed, e_di, e_dd, e_ib, e_db;
        logic [15:0] rq_addr[$];
        int rq_due[$];
        mem_rvld = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (!rst) begin
                check_eq("rst_ctl", 32'(ctl), 32'd0);
                check_eq("rst_mem", {mem_addr, mem_wdata}, 32'd0);
                check_eq("rst_fill", 32'({fill_data, fill_word_sel}), 32'd0);
                rq_addr.delete(); rq_due.delete();
                mem_rvld = 1'b0;
                m_kind = 0; s_exp = 0; m_free = cyc + 1; rr_pref_d = 1;
                continue;
            end
            {e_en, e_wr, e_ack, e_wei, e_wed, e_di, e_dd, e_ib, e_db} = '0;
            if (m_kind == 1 && cyc == m_start + 1) begin
                e_en = 1; e_wr = 1; e_ack = 1; e_db = 1;
            end
            if (m_kind >= 2) begin
                is_d = (m_kind == 3);
                act  = cyc >= m_start + 1 && (m_done < 0 || cyc <= m_done);
                e_en = cyc >= m_start + 1 && cyc <= m_start + 8;
                e_ib = act && !is_d;
                e_db = act && is_d;
                if (s_exp) begin e_wei = !is_d; e_wed = is_d; end
                if (cyc == m_done) begin
                    e_di = !is_d; e_dd = is_d; m_free = cyc + 1;
                end
            end
            check_eq("ctl", 32'(ctl), 32'({e_en, e_wr, e_ack, e_wei, e_wed, e_di, e_dd,
                                           e_di, e_dd, e_ib, e_db}));
            if (e_en && m_kind == 1) begin
                check_eq("wr_addr", 32'(mem_addr), 32'(m_addr));
                check_eq("wr_data", 32'(mem_wdata), 32'(m_wdata));
            end
            if (e_en && m_kind >= 2)
                check_eq("rd_addr", 32'(mem_addr),
                         32'({m_addr[15:4], 3'(cyc - m_start - 1), 1'b0}));
            if (s_exp) begin
                check_eq("fill_data", 32'(fill_data), 32'(s_data));
                check_eq("word_sel", 32'(fill_word_sel), 32'(s_sel));
                s_exp = 0;
            end
            // main memory behaviour
            if (mem_en && mem_wr) memw[mem_addr] = mem_wdata;
            if (mem_en && !mem_wr) begin
                rq_addr.push_back(mem_addr);
                rq_due.push_back(cyc + L);
            end
            mem_rvld = 1'b0;
            if (rq_addr.size() > 0 && rq_due[0] <= cyc && !(gap_mode && $urandom_range(0, 1) == 0)) begin
                mem_rvld = 1'b1;
                mem_rdata = memval(rq_addr.pop_front());
                void'(rq_due.pop_front());
            end else if (spur && rq_addr.size() == 0) begin
                mem_rvld = 1'b1;
                mem_rdata = 16'($urandom);
            end
            if (mem_rvld && m_kind >= 2 && cyc >= m_start + 1 && m_ret < 8) begin
                s_exp  = 1;
                s_data = memval({m_addr[15:4], 3'(m_ret), 1'b0});
                s_sel  = 8'b1 << m_ret;
                m_ret++;
                if (m_ret == 8) m_done = cyc + 2;
            end
            // arbitration in an idle cycle
            if (cyc >= m_free && (dwr_req || dfill_req || ifill_req)) begin
                m_start = cyc;
                if (dwr_req) begin
                    m_kind = 1; m_addr = dwr_addr; m_wdata = dwr_data; m_free = cyc + 2;
                end else begin
`ifdef CACHE_ARB_RR_EN
                    pick = dfill_req && (!ifill_req || rr_pref_d);
`else
                    pick = dfill_req;
`endif
                    m_kind = pick ? 3 : 2;
                    m_addr = pick ? dfill_addr : ifill_addr;
                    m_free = 1 << 30; m_ret = 0; m_done = -1;
                    rr_pref_d = !pick;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ifill_req = 1'b0; dfill_req = 1'b0; dwr_req = 1'b0;
        ifill_addr = '0; dfill_addr = '0; dwr_addr = '0; dwr_data = '0;
        #1 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;

        // I fill alone; address change after grant must be ignored
        ifill_addr = 16'h1234; ifill_req = 1'b1;
        repeat (3) tick();
        ifill_addr = 16'hFFFF;
        drain(100);

        // single write-through
        dwr_addr = 16'h00A0; dwr_data = 16'hBEEF; dwr_req = 1'b1;
        drain(20);

        // all three at once
        dwr_addr = 16'h0042; dwr_data = 16'h1357; dwr_req = 1'b1;
        dfill_addr = 16'h0040; dfill_req = 1'b1;
        ifill_addr = 16'h2468; ifill_req = 1'b1;
        drain(200);

        // gapped returns, then stray mem_rvld while idle
        gap_mode = 1'b1;
        dfill_addr = 16'h5678; dfill_req = 1'b1;
        drain(200);
        gap_mode = 1'b0;
        spur = 1'b1;
        repeat (4) tick();
        spur = 1'b0;
        repeat (2) tick();

        // reset in the middle of a D fill, then a clean D fill
        dfill_addr = 16'h9AB0; dfill_req = 1'b1;
        repeat (5) tick();
        rst = 1'b0; dfill_req = 1'b0;
        repeat (2) tick();
        rst = 1'b1; dfill_req = 1'b1;
        drain(100);

        // I and D fill requests held continuously
        repeat (70) begin
            tick();
            if (!ifill_req) begin ifill_req = 1'b1; ifill_addr = 16'($urandom); end
            if (!dfill_req) begin dfill_req = 1'b1; dfill_addr = 16'($urandom); end
        end
        ifill_req = 1'b0; dfill_req = 1'b0;
        repeat (20) tick();

        // random traffic over a small shared address window
        repeat (1500) begin
            tick();
            if ($urandom_range(0, 99) == 0) gap_mode = ~gap_mode;
            if (!dwr_req && $urandom_range(0, 9) == 0) begin
                dwr_req = 1'b1; dwr_addr = 16'($urandom_range(0, 255)); dwr_data = 16'($urandom);
            end
            if (!dfill_req && $urandom_range(0, 5) == 0) begin
                dfill_req = 1'b1; dfill_addr = 16'($urandom_range(0, 255));
            end
            if (!ifill_req && $urandom_range(0, 5) == 0) begin
                ifill_req = 1'b1; ifill_addr = 16'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 15) == 0) ifill_addr = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) dwr_data = 16'($urandom);
        end
        drain(800);
        gap_mode = 1'b0;
        repeat (3) tick();

        check_eq("timeouts", 32'(timeouts), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Sequences and shares the single multi-cycle main memory among three requesters: I-cache block fill, D-cache block fill and D-cache write-through.
- Fills: issues the 8 word reads of a 16-byte block, steers returned words into the owning cache's data array with a one-hot word select, then commits the tag.
- Writes: issues write-throughs as single memory writes.
- Placement: between the I/D cache arrays and the main memory model; replaces per-cache fill sequencing in the cache controller.

## Interface
Parameters:
- MEM_LATENCY, 4, cycles from a read issue (mem_en=1, mem_wr=0) to its mem_rvld pulse; must be ≥1
- ADDR_W, 16, address width
- DATA_W, 16, data width

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ifill_req  in  1  I-cache miss fill request; level, held until ifill_done
- ifill_addr  in  ADDR_W  I-cache miss address
- dfill_req  in  1  D-cache miss fill request; level, held until dfill_done
- dfill_addr  in  ADDR_W  D-cache miss address
- dwr_req  in  1  D-cache write-through request; level, held until dwr_ack
- dwr_addr  in  ADDR_W  write address
- dwr_data  in  DATA_W  write data
- dwr_ack  out  1  one-cycle pulse when the write is issued to memory
- mem_en  out  1  memory access enable
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvld  in  1  read data valid
- fill_data  out  DATA_W  registered copy of mem_rdata
- fill_word_sel  out  8  one-hot word select for fill_data
- fill_we_i  out  1  I-cache data-array write strobe
- fill_we_d  out  1  D-cache data-array write strobe
- tag_we_i  out  1  I-cache tag write strobe; equals ifill_done
- tag_we_d  out  1  D-cache tag write strobe; equals dfill_done
- ifill_done  out  1  one-cycle pulse: I fill complete
- dfill_done  out  1  one-cycle pulse: D fill complete
- ibusy  out  1  I fill in progress; drives fetch stall
- dbusy  out  1  D fill or write in progress; drives memory-stage stall

## Operation
- States:
  - IDLE: arbitrate among requests.
  - WRITE: issue the write-through.
  - FILL: issue reads and collect returned words.
  - TAG: commit the tag.
- IDLE arbitration, default priority: dwr_req > dfill_req > ifill_req. The winner's address, data and owner (I or D) are latched.
- Inputs are not re-sampled until the state returns to IDLE. Address or data changes mid-operation are ignored.
- WRITE, one cycle:
  - mem_en=1, mem_wr=1, mem_addr=latched dwr_addr, mem_wdata=latched dwr_data.
  - dwr_ack=1.
  - Next state IDLE.
- FILL:
  - Issue counter ic (3-bit) drives mem_addr = {blk[ADDR_W-1:4], ic, 1'b0}, mem_en=1, mem_wr=0.
  - Issue proceeds for 8 consecutive cycles, ic 0→7; mem_en=0 after the 8th read.
  - Return counter rc (4-bit) increments on each mem_rvld.
  - Cycle after each mem_rvld:
    - fill_data = captured mem_rdata.
    - fill_word_sel = onehot(rc).
    - fill_we_i or fill_we_d = 1 for the owning cache.
  - When rc reaches 8, next state is TAG.
- TAG, one cycle: tag_we_x and x_done asserted for the owner. Next state IDLE.
- Busy flags:
  - ibusy = 1 in FILL/TAG with owner I.
  - dbusy = 1 in WRITE, or FILL/TAG with owner D.
- Ignored inputs:
  - mem_rvld outside FILL.
  - mem_rvld beyond 8 returns.
  - Requests arriving during a busy period are held by the requester and arbitrated at the next IDLE.
- Back-to-back: a pending request is granted in the IDLE cycle following TAG or WRITE. IDLE lasts at least one cycle between operations.

## Timing
- Reset (rst=0, asynchronous):
  - State = IDLE; counters = 0; RR pointer = D.
  - All outputs = 0, including mem_addr, mem_wdata, fill_data, fill_word_sel.
- Reset mid-fill aborts the fill: no tag write and no done pulse.
- Write: request seen in IDLE at cycle 0 → mem_en/mem_wr/dwr_ack at cycle 1 → IDLE at cycle 2.
- Fill: request seen at cycle 0 →
  - reads issued cycles 1–8;
  - mem_rvld cycles 1+L … 8+L, where L = MEM_LATENCY;
  - fill_we cycles 2+L … 9+L;
  - memory returns are not guaranteed consecutive; completion waits for all 8 pulses, which the bench checks under gapped mem_rvld;
  - TAG and done at cycle 10+L with consecutive returns;
  - IDLE at 11+L.
- L=4: done at cycle 14.
- Done and ack pulses are registered, exactly one cycle wide.

## Configuration
- CACHE_ARB_RR_EN defined: fill arbitration between I and D alternates. The fill class served last loses the next tie; dwr_req keeps top priority.
- CACHE_ARB_RR_EN undefined: fixed priority dwr > dfill > ifill; no RR pointer register is built.

## Structure
- Package cache_arb_pkg:
  - state enum {IDLE, WRITE, FILL, TAG};
  - WORDS_PER_BLOCK = 8;
  - WORD_IDX_W = 3;
  - owner encoding OWN_I/OWN_D.
- One sub-module, word_onehot: 3-bit index → 8-bit one-hot, purely combinational, drives fill_word_sel.

## Test plan
- I fill alone, L=4, ifill_addr=16'h1234:
  - mem_addr sequence 1230,1232,…,123E on cycles 1–8;
  - fill_we_i with fill_word_sel 01,02,…,80;
  - ifill_done and tag_we_i at cycle 14.
- Write: dwr_addr=16'h00A0, dwr_data=16'hBEEF → cycle 1 shows mem_en=1, mem_wr=1, mem_addr=00A0, mem_wdata=BEEF, dwr_ack=1; dbusy high in cycle 1 only.
- Simultaneous dwr, dfill and ifill at cycle 0 → WRITE first, then D fill, then I fill. Each requester holds its request until its own ack/done and drops it that cycle. ibusy stays 0 until the D fill's TAG has passed.
- Gapped mem_rvld (8 pulses spread over 20 cycles) → 8 correctly ordered fill_we strobes; done only after the 8th; extra mem_rvld in IDLE produces no strobe.
- rst pulled low at cycle 5 of a D fill → all outputs 0 immediately; no dfill_done; after release, a new dfill_req completes normally.
- With CACHE_ARB_RR_EN, ifill and dfill both held continuously → grants alternate D, I, D, I; without the macro, D is served on every tie.
